arcsin_seq_ctrl: RTL
====================

ARCSIN_SEQ_CTRL -- requirements
Module: arcsin_seq_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80001000, base address of the 32-byte register window.
REQ-002 Parameter TIMEOUT, default 1024, the maximum number of cycles spent in WAIT before the operation is aborted.
REQ-003 clk_i  input  1  system clock; all logic is rising-edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 bus_req_i, bus_we_i  input  1 each  bus request and write strobe.
REQ-006 bus_addr_bi, bus_wdata_bi  input  32 each  bus address and write data.
REQ-007 bus_be_bi  input  4  byte enables; ignored, full-word access only.
REQ-008 bus_ack_o  output  1  request accepted.
REQ-009 bus_resp_o  output  1  read response valid.
REQ-010 bus_rdata_bo  output  32  read data.
REQ-011 core_start_o  output  1  one-cycle start pulse to the sequential arcsin core.
REQ-012 core_x_bo  output  32  operand to the core.
REQ-013 core_done_i  input  1  core result-valid pulse.
REQ-014 core_y_bi  input  32  core result, valid while core_done_i is high.
REQ-015 irq_o  output  1  level interrupt, equal to STATUS.done AND CTRL.ie.

Function
REQ-016 bus_ack_o SHALL equal bus_req_i combinationally; every request is accepted in the cycle it is presented.
REQ-017 Register map, as offsets from BASE_ADDR:
- 0x00 CTRL: bit0 start (write-1 pulse, reads 0), bit1 ie (R/W).
- 0x04 STATUS: bit0 busy, bit1 done, bit2 err, bit3 ovr; bits1-3 are write-1-to-clear.
- 0x08 X (R/W).
- 0x0C Y (RO).
- 0x10 CYCLES (RO).
REQ-018 An accepted read SHALL assert bus_resp_o for exactly one cycle, in the cycle after acceptance, with the register value as of the acceptance cycle.
REQ-019 A read of an unmapped address inside or outside the window SHALL give no response; writes to unmapped or RO addresses SHALL be ignored.
REQ-020 FSM states IDLE, START, WAIT.
REQ-021 Transitions:
- IDLE->START on an accepted write of CTRL with bit0=1.
- START->WAIT unconditionally.
- WAIT->IDLE on core_done_i, or when the WAIT cycle counter reaches TIMEOUT.
REQ-022 core_start_o SHALL be high exactly during START, i.e. the cycle after the start write; core_x_bo SHALL equal register X at all times.
REQ-023 STATUS.busy SHALL be 1 in START and WAIT.
REQ-024 Entering START SHALL clear done, err and CYCLES.
REQ-025 CYCLES SHALL increment every cycle in START and WAIT, saturating at 2^32-1.
REQ-026 On core_done_i in WAIT, Y SHALL capture core_y_bi and done SHALL be set, both visible the next cycle.
REQ-027 On timeout, err SHALL be set, Y SHALL be left unchanged, and the FSM SHALL return to IDLE.
REQ-028 core_done_i in IDLE or START SHALL be ignored.
REQ-029 A start write while busy SHALL be ignored and SHALL set ovr.
REQ-030 A write to X while busy SHALL be ignored and SHALL set ovr.
REQ-031 A hardware set and a write-1-to-clear of the same STATUS bit in the same cycle: the set SHALL win.

Reset
REQ-032 Reset SHALL force:
- FSM to IDLE;
- X, Y, CYCLES, CTRL.ie and all STATUS bits to 0;
- bus_resp_o, bus_rdata_bo, core_start_o and irq_o to 0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation immediately; a later core_done_i SHALL be ignored.

Structure
REQ-034 The state enum, register offsets and STATUS bit indices SHALL live in package arcsin_ctrl_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the register file, FSM and counters are all local.

Verification
REQ-036 Write X=32'h3F000000, then CTRL=1; core model returns done with Y=32'h3F060A92 after 10 cycles:
- core_start_o rises one cycle after the CTRL write;
- STATUS reads 0x2;
- Y reads 32'h3F060A92;
- CYCLES reads 11.
REQ-037 CTRL=3 (ie=1); on completion irq_o=1; write STATUS=0x2 -> irq_o=0 next cycle.
REQ-038 TIMEOUT=16 with no core_done_i: STATUS=0x4 after 17 cycles, Y unchanged.
REQ-039 Start, then a start write and an X write while busy: X unchanged, exactly one core_start_o pulse, STATUS.ovr=1.
REQ-040 Reset asserted in WAIT, core_done_i pulsed afterwards: Y=0, STATUS=0, FSM IDLE.
REQ-041 Read of BASE_ADDR+0x14 -> no bus_resp_o; write STATUS=0x2 in the same cycle as core_done_i -> done reads 1.

Source files
------------

// File: rtl/arcsin_seq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : arcsin_ctrl_pkg
// Brief   : Shared types and register map for the arcsin sequencer controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package arcsin_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Register offsets from the window base
  localparam logic [31:0] c_off_ctrl   = 32'h00;
  localparam logic [31:0] c_off_status = 32'h04;
  localparam logic [31:0] c_off_x      = 32'h08;
  localparam logic [31:0] c_off_y      = 32'h0C;
  localparam logic [31:0] c_off_cycles = 32'h10;

  localparam int c_ctrl_start = 0;
  localparam int c_ctrl_ie    = 1;

  localparam int c_st_busy = 0;
  localparam int c_st_done = 1;
  localparam int c_st_err  = 2;
  localparam int c_st_ovr  = 3;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic err, input logic ovr);
    logic [31:0] w_word;
    w_word            = '0;
    w_word[c_st_busy] = busy;
    w_word[c_st_done] = done;
    w_word[c_st_err]  = err;
    w_word[c_st_ovr]  = ovr;
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arcsin_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : arcsin_seq_ctrl_if
// Brief   : Register bus between a host (master) and the sequencer (slave).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface arcsin_seq_ctrl_if;

  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [31:0] bus_wdata_bi;
  logic [3:0]  bus_be_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_wdata_bi, bus_be_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_wdata_bi, bus_be_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

endinterface

`default_nettype wire

// File: rtl/arcsin_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : arcsin_seq_ctrl
// Brief   : Register-mapped launcher for a sequential arcsin core with timeout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arcsin_seq_ctrl
  import arcsin_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h80001000,
  parameter int          TIMEOUT   = 1024
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  arcsin_seq_ctrl_if.slave   bus,
  output logic               core_start_o,
  output logic [31:0]        core_x_bo,
  input  wire logic          core_done_i,
  input  wire logic [31:0]   core_y_bi,
  output logic               irq_o
);

  localparam int c_wcw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  logic               r_core_start;
  logic [c_wcw-1:0]   r_wait_cnt;
  logic [31:0]        r_cycles;
  logic [31:0]        r_x;
  logic [31:0]        r_y;
  logic               r_ie;
  logic               r_done;
  logic               r_err;
  logic               r_ovr;
  logic               r_resp;
  logic [31:0]        r_rdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_busy;
  logic        w_hit_ctrl;
  logic        w_hit_status;
  logic        w_hit_x;
  logic        w_hit_y;
  logic        w_hit_cycles;
  logic        w_start_wr;
  logic        w_launch;
  logic        w_x_wr;
  logic        w_ovr_set;
  logic        w_fin;
  logic        w_tmo;
  logic        w_clr_done;
  logic        w_clr_err;
  logic        w_clr_ovr;
  logic        w_rd_hit;
  logic [31:0] w_rd_val;

  assign w_wr   = bus.bus_req_i & bus.bus_we_i;
  assign w_rd   = bus.bus_req_i & ~bus.bus_we_i;
  assign w_busy = (r_state != ST_IDLE);

  assign w_hit_ctrl   = (bus.bus_addr_bi == BASE_ADDR + c_off_ctrl);
  assign w_hit_status = (bus.bus_addr_bi == BASE_ADDR + c_off_status);
  assign w_hit_x      = (bus.bus_addr_bi == BASE_ADDR + c_off_x);
  assign w_hit_y      = (bus.bus_addr_bi == BASE_ADDR + c_off_y);
  assign w_hit_cycles = (bus.bus_addr_bi == BASE_ADDR + c_off_cycles);

  assign w_start_wr = w_wr & w_hit_ctrl & bus.bus_wdata_bi[c_ctrl_start];
  assign w_launch   = w_start_wr & ~w_busy;
  assign w_x_wr     = w_wr & w_hit_x;
  assign w_ovr_set  = w_busy & (w_start_wr | w_x_wr);

  // Completion beats the timeout when both land on the same WAIT cycle
  assign w_fin = (r_state == ST_WAIT) & core_done_i;
  assign w_tmo = (r_state == ST_WAIT) & ~core_done_i &
                 (r_wait_cnt == c_wcw'(TIMEOUT - 1));

  assign w_clr_done = w_wr & w_hit_status & bus.bus_wdata_bi[c_st_done];
  assign w_clr_err  = w_wr & w_hit_status & bus.bus_wdata_bi[c_st_err];
  assign w_clr_ovr  = w_wr & w_hit_status & bus.bus_wdata_bi[c_st_ovr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_core_start <= 1'b0;
      r_wait_cnt   <= '0;
      r_cycles     <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state      <= ST_START;
            r_core_start <= 1'b1;
            r_cycles     <= '0;
          end
        end
        ST_START: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + c_wcw'(1);
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
          if (w_fin || w_tmo) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Hardware sets take priority over write-1-to-clear on the same bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x    <= '0;
      r_y    <= '0;
      r_ie   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_x_wr && !w_busy) r_x <= bus.bus_wdata_bi;
      if (w_wr && w_hit_ctrl) r_ie <= bus.bus_wdata_bi[c_ctrl_ie];
      if (w_fin) r_y <= core_y_bi;
      r_done <= w_fin | (r_done & ~w_launch & ~w_clr_done);
      r_err  <= w_tmo | (r_err & ~w_launch & ~w_clr_err);
      r_ovr  <= w_ovr_set | (r_ovr & ~w_clr_ovr);
    end
  end

  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_val = '0;
    if (w_hit_ctrl) begin
      w_rd_hit            = 1'b1;
      w_rd_val[c_ctrl_ie] = r_ie;
    end else if (w_hit_status) begin
      w_rd_hit = 1'b1;
      w_rd_val = pack_status(w_busy, r_done, r_err, r_ovr);
    end else if (w_hit_x) begin
      w_rd_hit = 1'b1;
      w_rd_val = r_x;
    end else if (w_hit_y) begin
      w_rd_hit = 1'b1;
      w_rd_val = r_y;
    end else if (w_hit_cycles) begin
      w_rd_hit = 1'b1;
      w_rd_val = r_cycles;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp <= w_rd & w_rd_hit;
      if (w_rd && w_rd_hit) r_rdata <= w_rd_val;
    end
  end

  assign bus.bus_ack_o    = bus.bus_req_i;
  assign bus.bus_resp_o   = r_resp;
  assign bus.bus_rdata_bo = r_rdata;
  assign core_start_o     = r_core_start;
  assign core_x_bo        = r_x;
  assign irq_o            = r_done & r_ie;

endmodule

`default_nettype wire
